// File: rtl/cmp_rr_arbiter.sv
// Round-robin arbiter that shares one registered magnitude comparator among R requesters.
// Each winner's operands are issued to the comparator, and the flags come back as a one-cycle response pulse.
module cmp_rr_arbiter #(
    parameter int N = 4,
    parameter int R = 4,
    localparam int IW = $clog2(R)
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic [R-1:0]    req_valid,
    input  logic [R*N-1:0]  req_a,
    input  logic [R*N-1:0]  req_b,
    output logic [R-1:0]    req_ready,
    output logic [R-1:0]    rsp_valid,
    output logic [IW-1:0]   rsp_id,
    output logic            rsp_gt,
    output logic            rsp_lt,
    output logic            rsp_eq,
    output logic            busy,
    output logic [N-1:0]    cmp_a,
    output logic [N-1:0]    cmp_b,
    input  logic            cmp_gt,
    input  logic            cmp_lt,
    input  logic            cmp_eq
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ISSUE = 2'b01,
        DONE  = 2'b10
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   gnt_id_p1;
    logic [N-1:0]    op_a_p1;
    logic [N-1:0]    op_b_p1;
    logic [IW-1:0]   gnt_idx;
    logic            gnt_found;
    logic            grant;
    logic [N-1:0]    a_slice [R];
    logic [N-1:0]    b_slice [R];

    for (genvar i = 0; i < R; i++) begin : g_slice
        assign a_slice[i] = req_a[i*N +: N];
        assign b_slice[i] = req_b[i*N +: N];
    end

    // Rotating priority: first pending requester after the last winner, wrapping at R.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        for (int k = 1; k <= R; k++) begin
            logic [IW:0] cand;
            cand = {1'b0, ptr_q} + (IW+1)'(k);
            if (cand >= (IW+1)'(R)) begin
                cand = cand - (IW+1)'(R);
            end
            if (!gnt_found && req_valid[cand[IW-1:0]]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand[IW-1:0];
            end
        end
    end

    // The reset term keeps req_ready low while reset_n is held, even though the state is already IDLE.
    assign grant = (state_q == IDLE) && gnt_found && reset_n;

    always_comb begin
        state_d   = IDLE;
        req_ready = '0;
        rsp_valid = '0;
        rsp_id    = '0;
        rsp_gt    = 1'b0;
        rsp_lt    = 1'b0;
        rsp_eq    = 1'b0;
        case (state_q)
            IDLE: begin
                if (grant) begin
                    req_ready[gnt_idx] = 1'b1;
                    state_d            = ISSUE;
                end
            end
            ISSUE: begin
                state_d = DONE;
            end
            DONE: begin
                rsp_valid[gnt_id_p1] = 1'b1;
                rsp_id               = gnt_id_p1;
                rsp_gt               = cmp_gt;
                rsp_lt               = cmp_lt;
                rsp_eq               = cmp_eq;
                state_d              = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign busy  = (state_q != IDLE);
    assign cmp_a = op_a_p1;
    assign cmp_b = op_b_p1;

    // Stage p1: captured operands feed the comparator; its flags return one cycle later, in DONE.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            ptr_q     <= IW'(R - 1);
            gnt_id_p1 <= '0;
            op_a_p1   <= '0;
            op_b_p1   <= '0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                ptr_q     <= gnt_idx;
                gnt_id_p1 <= gnt_idx;
                op_a_p1   <= a_slice[gnt_idx];
                op_b_p1   <= b_slice[gnt_idx];
            end
        end
    end

endmodule

// File: tb/tb_cmp_rr_arbiter.sv
// Bench for cmp_rr_arbiter: directed vector table, hand-written reset sequence, randomized run against a transaction model.
module tb_cmp_rr_arbiter;

    localparam int N  = 4;
    localparam int R  = 4;
    localparam int IW = $clog2(R);

    logic            clk = 1'b0;
    logic            reset_n = 1'b0;
    logic [R-1:0]    req_valid = '0;
    logic [R*N-1:0]  req_a = '0;
    logic [R*N-1:0]  req_b = '0;
    logic [R-1:0]    req_ready;
    logic [R-1:0]    rsp_valid;
    logic [IW-1:0]   rsp_id;
    logic            rsp_gt, rsp_lt, rsp_eq, busy;
    logic [N-1:0]    cmp_a, cmp_b;
    logic            cmp_gt, cmp_lt, cmp_eq;

    int total = 0;
    int bad   = 0;

    cmp_rr_arbiter #(.N(N), .R(R)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
        .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_id(rsp_id),
        .rsp_gt(rsp_gt), .rsp_lt(rsp_lt), .rsp_eq(rsp_eq), .busy(busy),
        .cmp_a(cmp_a), .cmp_b(cmp_b),
        .cmp_gt(cmp_gt), .cmp_lt(cmp_lt), .cmp_eq(cmp_eq)
    );

    always #5 clk = ~clk;

    // Shared comparator: registered, one-cycle latency, flags cleared by reset
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmp_gt <= 1'b0;
            cmp_lt <= 1'b0;
            cmp_eq <= 1'b0;
        end else begin
            cmp_gt <= (cmp_a > cmp_b);
            cmp_lt <= (cmp_a < cmp_b);
            cmp_eq <= (cmp_a == cmp_b);
        end
    end

    typedef struct {
        logic [R-1:0]   valid;
        logic [R*N-1:0] a;
        logic [R*N-1:0] b;
        logic [R-1:0]   rdy;
        logic [R-1:0]   rv;
        int             id;
        logic [2:0]     fl;
        logic           bsy;
    } vec_t;

    localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001, NO = 3'b000;

    vec_t tbl[$];

    function automatic vec_t mk(logic [R-1:0] v, logic [R*N-1:0] a, logic [R*N-1:0] b,
                                logic [R-1:0] rdy, logic [R-1:0] rv, int id,
                                logic [2:0] fl, logic bsy);
        vec_t t;
        t.valid = v; t.a = a; t.b = b; t.rdy = rdy; t.rv = rv;
        t.id = id; t.fl = fl; t.bsy = bsy;
        return t;
    endfunction

    task automatic check_out(input string nm, input logic [R-1:0] er, input logic [R-1:0] ev,
                             input int eid, input logic [2:0] efl, input logic eb);
        total++;
        if (req_ready !== er || rsp_valid !== ev || int'(rsp_id) != eid ||
            {rsp_gt, rsp_lt, rsp_eq} !== efl || busy !== eb) begin
            bad++;
            $display("FAIL %s: got ready=%b rsp_valid=%b id=%0d gt/lt/eq=%b%b%b busy=%b; want ready=%b rsp_valid=%b id=%0d gt/lt/eq=%b busy=%b",
                     nm, req_ready, rsp_valid, rsp_id, rsp_gt, rsp_lt, rsp_eq, busy,
                     er, ev, eid, efl, eb);
        end
    endtask

    task automatic check_cmp(input string nm, input logic [N-1:0] ea, input logic [N-1:0] eb);
        total++;
        if (cmp_a !== ea || cmp_b !== eb) begin
            bad++;
            $display("FAIL %s: got cmp_a=%h cmp_b=%h; want cmp_a=%h cmp_b=%h", nm, cmp_a, cmp_b, ea, eb);
        end
    endtask

    // Transaction model: cycles the arbiter stays occupied, last winner, operands in flight
    int           m_free;
    int           m_last;
    int           m_who;
    int           m_a, m_b;
    logic [R-1:0] last_ready;

    task automatic do_reset();
        reset_n   = 1'b0;
        req_valid = '1;
        repeat (2) @(posedge clk);
        #1;
        check_out("reset_state", '0, '0, 0, NO, 1'b0);
        check_cmp("reset_cmp", '0, '0);
        req_valid  = '0;
        reset_n    = 1'b1;
        m_free     = 0;
        m_last     = R - 1;
        m_who      = 0;
        m_a        = 0;
        m_b        = 0;
        last_ready = '0;
    endtask

    function automatic logic [N-1:0] rand_val();
        case ($urandom_range(0, 3))
            0:       return '0;
            1:       return '1;
            default: return N'($urandom_range(0, (1 << N) - 1));
        endcase
    endfunction

    task automatic model_check();
        logic [R-1:0] er, ev;
        logic [2:0]   efl;
        int           eid, g;
        er = '0; ev = '0; efl = NO; eid = 0; g = -1;
        if (m_free == 0) begin
            for (int d = 1; d <= R; d++) begin
                int c;
                c = (m_last + d) % R;
                if (g < 0 && req_valid[c]) g = c;
            end
            if (g >= 0) er[g] = 1'b1;
        end
        if (m_free == 1) begin
            ev[m_who] = 1'b1;
            eid       = m_who;
            efl       = {m_a > m_b, m_a < m_b, m_a == m_b};
        end
        check_out("rand", er, ev, eid, efl, m_free != 0);
        if (m_free == 2) check_cmp("rand_cmp", N'(m_a), N'(m_b));
        last_ready = req_ready;
        if (m_free > 0) begin
            m_free--;
        end else if (g >= 0) begin
            m_free = 2;
            m_last = g;
            m_who  = g;
            m_a    = int'(req_a[g*N +: N]);
            m_b    = int'(req_b[g*N +: N]);
        end
    endtask

    initial begin
        // All four contending: a_i = i, b_i = 2
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0001, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0001, 0, LT, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0010, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0010, 1, LT, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0100, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0100, 2, EQ, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b1000, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b1000, 3, GT, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0001, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'hF, 16'h3210, 16'h2222, 4'b0000, 4'b0001, 0, LT, 1));
        tbl.push_back(mk(4'h0, 16'h3210, 16'h2222, 4'b0000, 4'b0000, 0, NO, 0));
        // Single request 9 vs 3
        tbl.push_back(mk(4'h1, 16'h0009, 16'h0003, 4'b0001, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h0, 16'h0009, 16'h0003, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h0, 16'h0009, 16'h0003, 4'b0000, 4'b0001, 0, GT, 1));
        // Unsigned extremes, back-to-back grants
        tbl.push_back(mk(4'h2, 16'h00F0, 16'h00F0, 4'b0010, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h0, 16'h00F0, 16'h00F0, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h0, 16'h00F0, 16'h00F0, 4'b0000, 4'b0010, 1, EQ, 1));
        tbl.push_back(mk(4'h4, 16'h0000, 16'h0F00, 4'b0100, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h0, 16'h0000, 16'h0F00, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h0, 16'h0000, 16'h0F00, 4'b0000, 4'b0100, 2, LT, 1));
        tbl.push_back(mk(4'h8, 16'hF000, 16'h0000, 4'b1000, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h0, 16'hF000, 16'h0000, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h0, 16'hF000, 16'h0000, 4'b0000, 4'b1000, 3, GT, 1));
        // Wrap-around scan after a grant to 3
        tbl.push_back(mk(4'hA, 16'h7050, 16'h7060, 4'b0010, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h8, 16'h7050, 16'h7060, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h8, 16'h7050, 16'h7060, 4'b0000, 4'b0010, 1, LT, 1));
        tbl.push_back(mk(4'h8, 16'h7050, 16'h7060, 4'b1000, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h0, 16'h7050, 16'h7060, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h0, 16'h7050, 16'h7060, 4'b0000, 4'b1000, 3, EQ, 1));
        // Request raised while busy waits for IDLE
        tbl.push_back(mk(4'h1, 16'h0002, 16'h0001, 4'b0001, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h4, 16'h0300, 16'h0300, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h4, 16'h0300, 16'h0300, 4'b0000, 4'b0001, 0, GT, 1));
        tbl.push_back(mk(4'h4, 16'h0300, 16'h0300, 4'b0100, 4'b0000, 0, NO, 0));
        tbl.push_back(mk(4'h0, 16'h0300, 16'h0300, 4'b0000, 4'b0000, 0, NO, 1));
        tbl.push_back(mk(4'h0, 16'h0300, 16'h0300, 4'b0000, 4'b0100, 2, EQ, 1));
        tbl.push_back(mk(4'h0, 16'h0300, 16'h0300, 4'b0000, 4'b0000, 0, NO, 0));

        do_reset();
        for (int i = 0; i < tbl.size(); i++) begin
            req_valid = tbl[i].valid;
            req_a     = tbl[i].a;
            req_b     = tbl[i].b;
            @(negedge clk);
            check_out($sformatf("vec%0d", i), tbl[i].rdy, tbl[i].rv, tbl[i].id, tbl[i].fl, tbl[i].bsy);
            @(posedge clk);
            #1;
        end

        // Reset while ISSUE: in-flight operation dropped, requester 0 wins the tie afterwards
        do_reset();
        req_valid = 4'b0001; req_a = 16'h0001; req_b = 16'h0002;
        @(negedge clk);
        check_out("t6_grant", 4'b0001, '0, 0, NO, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 4'b0011; req_a = 16'h0041; req_b = 16'h0042;
        @(negedge clk);
        check_out("t6_issue", '0, '0, 0, NO, 1'b1);
        check_cmp("t6_issue_cmp", 4'h1, 4'h2);
        #1 reset_n = 1'b0;
        #1;
        check_out("t6_rst_now", '0, '0, 0, NO, 1'b0);
        check_cmp("t6_rst_cmp", '0, '0);
        @(posedge clk);
        @(negedge clk);
        check_out("t6_rst_hold", '0, '0, 0, NO, 1'b0);
        #1 reset_n = 1'b1;
        #1;
        check_out("t6_tie", 4'b0001, '0, 0, NO, 1'b0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_out("t6_issue2", '0, '0, 0, NO, 1'b1);
        @(posedge clk);
        #1;
        req_valid = 4'b0010;
        @(negedge clk);
        check_out("t6_rsp", '0, 4'b0001, 0, LT, 1'b1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_out("t6_next", 4'b0010, '0, 0, NO, 1'b0);
        @(posedge clk);
        #1;

        // Randomized traffic against the model
        do_reset();
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int i = 0; i < R; i++) begin
                logic hs;
                hs = req_valid[i] && last_ready[i];
                if (req_valid[i] && !hs) begin
                    if ($urandom_range(0, 7) == 0) req_valid[i] = 1'b0;
                end else if ($urandom_range(0, 2) == 0) begin
                    req_valid[i]     = 1'b1;
                    req_a[i*N +: N]  = rand_val();
                    req_b[i*N +: N]  = rand_val();
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
            @(negedge clk);
            model_check();
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
